gb_regfile_pair: RTL

- Second-generation SM83 (GameBoy) CPU register file.
- Holds A, F, B, C, D, E, H, L and the 16-bit SP.
- Adds N parametrised 8-bit read ports and a 16-bit pair read/write path (BC/DE/HL/SP/AF).
- Adds an increment/decrement unit (IDU) on pairs, for HL+/HL-, INC rr, DEC rr and PUSH/POP.
- Adds per-flag masked flag updates and optional write-to-read bypass.
- Sits between the decoder/control FSM and the ALU/address mux of the CPU core.

---
 rtl/gb_regfile_pair.sv | 121 ++++++++++++
 1 files changed

// File: rtl/gb_regfile_pair.sv
// SM83 register file: A/F/B/C/D/E/H/L plus SP, 8-bit read ports,
// 16-bit pair path, pair increment/decrement unit and masked flag merge.
module gb_regfile_pair #(
  parameter int          NUM_RD_PORTS = 2,
  parameter bit          BYPASS       = 1'b1,
  parameter logic [15:0] SP_RESET     = 16'hFFFE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr8_en,
  input  logic [2:0]                  wr8_sel,
  input  logic [7:0]                  wr8_data,
  input  logic                        wr16_en,
  input  logic [1:0]                  wr16_sel,
  input  logic                        wr16_af,
  input  logic [15:0]                 wr16_data,
  input  logic                        idu_en,
  input  logic [1:0]                  idu_sel,
  input  logic                        idu_dec,
  input  logic [3:0]                  flags_we,
  input  logic [3:0]                  flags_in,
  input  logic [3*NUM_RD_PORTS-1:0]   rd_sel,
  output logic [8*NUM_RD_PORTS-1:0]   rd_data,
  input  logic [1:0]                  rd16_sel,
  input  logic                        rd16_af,
  output logic [15:0]                 rd16_data,
  output logic [3:0]                  flags
);

  localparam logic [2:0] SEL_F = 3'd6;
  localparam logic [2:0] SEL_A = 3'd7;

  logic [7:0][7:0] regs_q;
  logic [7:0][7:0] regs_d;
  logic [15:0]     sp_q;
  logic [15:0]     sp_d;
  logic [15:0]     idu_cur;
  logic [15:0]     idu_res;
  logic [7:0][7:0] rd_src;
  logic [15:0]     sp_src;

  always_comb begin
    if (idu_sel == 2'd3) begin
      idu_cur = sp_q;
    end else begin
      idu_cur = {regs_q[{idu_sel, 1'b0}],
                 regs_q[{idu_sel, 1'b1}]};
    end
    idu_res = idu_dec ? idu_cur - 16'd1
                      : idu_cur + 16'd1;
  end

  // Later assignments win: IDU < flag merge/wr8 < wr16
  always_comb begin
    regs_d = regs_q;
    sp_d   = sp_q;
    if (idu_en) begin
      if (idu_sel == 2'd3) begin
        sp_d = idu_res;
      end else begin
        regs_d[{idu_sel, 1'b0}] = idu_res[15:8];
        regs_d[{idu_sel, 1'b1}] = idu_res[7:0];
      end
    end
    regs_d[SEL_F][7:4] = (regs_q[SEL_F][7:4] & ~flags_we)
                       | (flags_in & flags_we);
    if (wr8_en) begin
      regs_d[wr8_sel] = wr8_data;
    end
    if (wr16_en) begin
      if (wr16_sel == 2'd3) begin
        if (wr16_af) begin
          regs_d[SEL_A] = wr16_data[15:8];
          regs_d[SEL_F] = wr16_data[7:0];
        end else begin
          sp_d = wr16_data;
        end
      end else begin
        regs_d[{wr16_sel, 1'b0}] = wr16_data[15:8];
        regs_d[{wr16_sel, 1'b1}] = wr16_data[7:0];
      end
    end
    regs_d[SEL_F][3:0] = 4'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      sp_q   <= SP_RESET;
    end else begin
      regs_q <= regs_d;
      sp_q   <= sp_d;
    end
  end

  always_comb begin
    rd_src = BYPASS ? regs_d : regs_q;
    sp_src = BYPASS ? sp_d : sp_q;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
      assign rd_data[8*i +: 8] = rd_src[rd_sel[3*i +: 3]];
    end
  endgenerate

  always_comb begin
    if (rd16_sel != 2'd3) begin
      rd16_data = {rd_src[{rd16_sel, 1'b0}],
                   rd_src[{rd16_sel, 1'b1}]};
    end else if (rd16_af) begin
      rd16_data = {rd_src[SEL_A], rd_src[SEL_F][7:4], 4'h0};
    end else begin
      rd16_data = sp_src;
    end
  end

  assign flags = regs_q[SEL_F][7:4];

endmodule
